cdc_handshake_tx: RTL and testbench



---
 rtl/cdc_handshake_tx.sv | 158 +++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// cdc_handshake_tx
//
// Source-domain sender for a 4-phase req/ack bundled-data clock crossing.
// A word is captured on a local valid/ready handshake and driven on data_out.
// req_out is then raised and taken through a full 4-phase cycle against the
// asynchronous ack_in returned by the destination domain. ack_in passes
// through a local 2-flop synchronizer. An optional timeout aborts a request
// that is never acknowledged.
//
// Ports:
//   clk          in   source-domain clock
//   n_rst        in   asynchronous active-low reset
//   send_valid   in   local request to transfer send_data
//   send_data    in   word to transfer, sampled only on accept
//   send_ready   out  block can accept a word (IDLE and synchronized ack low)
//   req_out      out  registered 4-phase request to the destination domain
//   data_out     out  registered bundled data, stable whenever req_out=1
//   ack_in       in   asynchronous acknowledge from the destination domain
//   done         out  one-cycle pulse, transfer fully completed
//   timeout_err  out  one-cycle pulse, transfer aborted on timeout
//
// Parameters:
//   DATA_WIDTH   width of the transferred word
//   TIMEOUT      max cycles req_out stays high without a synchronized ack;
//                0 disables the timeout
// ---------------------------------------------------------------------------
module cdc_handshake_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  send_valid,
    input  logic [DATA_WIDTH-1:0] send_data,
    output logic                  send_ready,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  done,
    output logic                  timeout_err
);

    // Counter is wide enough to hold TIMEOUT, and never narrower than 1 bit
    // so that TIMEOUT=0 still elaborates cleanly.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACKLOW = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ackMeta_q, ackSync_q;
    logic                  reqOut_q, reqOut_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  timeoutErr_q, timeoutErr_d;
    logic                  sendReady;

    // A new word is only taken once the previous 4-phase cycle has fully
    // returned to zero on the ack side; a late ack after an abort therefore
    // keeps the sender blocked until it drops.
    assign sendReady = (state_q == IDLE) && !ackSync_q;

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ackMeta_q <= 1'b0;
            ackSync_q <= 1'b0;
        end else begin
            ackMeta_q <= ack_in;
            ackSync_q <= ackMeta_q;
        end
    end

    // State and registered outputs; every output of the block comes from
    // here so nothing combinational leaks into the destination domain.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            reqOut_q     <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            reqOut_q     <= reqOut_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Protocol FSM. An ack seen on the timeout cycle takes priority over the
    // abort. The counter saturates rather than wrapping.
    always_comb begin
        state_d      = state_q;
        reqOut_d     = reqOut_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        timeoutErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_valid && sendReady) begin
                    state_d  = REQ;
                    reqOut_d = 1'b1;
                    data_d   = send_data;
                    cnt_d    = '0;
                end
            end
            REQ: begin
                if (ackSync_q) begin
                    state_d  = ACKLOW;
                    reqOut_d = 1'b0;
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d      = ABORT;
                        reqOut_d     = 1'b0;
                        timeoutErr_d = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACKLOW: begin
                if (!ackSync_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ABORT: begin
                if (!ackSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                reqOut_d = 1'b0;
            end
        endcase
    end

    assign send_ready  = sendReady;
    assign req_out     = reqOut_q;
    assign data_out    = data_q;
    assign done        = done_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// tb_cdc_handshake_tx
//
// Three instances of cdc_handshake_tx (TIMEOUT=255, 4 and 0) share clock,
// reset and send_data; send_valid and ack_in are steered to the instance
// chosen by sel, and its outputs are muxed back for checking. Accepted words
// are queued and compared against data_out when req_out rises.
// ---------------------------------------------------------------------------
module tb_cdc_handshake_tx;

    typedef struct {
        string      tag;
        int         sel;
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       accept;
        logic       expReady;
        logic       expReq;
        logic [7:0] expData;
        logic       expDone;
        logic       expTerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       nRst;
    logic       sendValid;
    logic [7:0] sendData;
    logic       ackIn;
    int         sel;

    logic [2:0] validV, ackV, rdyV, reqV, doneV, terrV;
    logic [7:0] dataV [3];
    logic       rdyM, reqM, doneM, terrM;
    logic [7:0] dataM;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] expQ [$];
    logic       reqPrev;
    vec_t       vecs [$];

    // 100 MHz source clock.
    always #5 clk = ~clk;

    // Route the local request and the ack only to the instance under test.
    assign validV[0] = sendValid && (sel == 0);
    assign validV[1] = sendValid && (sel == 1);
    assign validV[2] = sendValid && (sel == 2);
    assign ackV[0]   = ackIn && (sel == 0);
    assign ackV[1]   = ackIn && (sel == 1);
    assign ackV[2]   = ackIn && (sel == 2);

    cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT(255)) u0 (
        .clk(clk), .n_rst(nRst), .send_valid(validV[0]), .send_data(sendData),
        .send_ready(rdyV[0]), .req_out(reqV[0]), .data_out(dataV[0]),
        .ack_in(ackV[0]), .done(doneV[0]), .timeout_err(terrV[0]));

    cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT(4)) u1 (
        .clk(clk), .n_rst(nRst), .send_valid(validV[1]), .send_data(sendData),
        .send_ready(rdyV[1]), .req_out(reqV[1]), .data_out(dataV[1]),
        .ack_in(ackV[1]), .done(doneV[1]), .timeout_err(terrV[1]));

    cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT(0)) u2 (
        .clk(clk), .n_rst(nRst), .send_valid(validV[2]), .send_data(sendData),
        .send_ready(rdyV[2]), .req_out(reqV[2]), .data_out(dataV[2]),
        .ack_in(ackV[2]), .done(doneV[2]), .timeout_err(terrV[2]));

    // Observe whichever instance is currently selected.
    always_comb begin
        rdyM  = rdyV[0];
        reqM  = reqV[0];
        doneM = doneV[0];
        terrM = terrV[0];
        dataM = dataV[0];
        case (sel)
            1: begin
                rdyM = rdyV[1]; reqM = reqV[1]; doneM = doneV[1];
                terrM = terrV[1]; dataM = dataV[1];
            end
            2: begin
                rdyM = rdyV[2]; reqM = reqV[2]; doneM = doneV[2];
                terrM = terrV[2]; dataM = dataV[2];
            end
            default: ;
        endcase
    end

    function automatic vec_t mk(string tag, int s, logic v, logic [7:0] d, logic a,
                                logic acc, logic er, logic eq, logic [7:0] ed,
                                logic edn, logic et);
        vec_t r;
        r.tag = tag; r.sel = s; r.valid = v; r.data = d; r.ack = a; r.accept = acc;
        r.expReady = er; r.expReq = eq; r.expData = ed; r.expDone = edn; r.expTerr = et;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the expected word whenever a new request is launched.
    task automatic scoreCheck();
        logic [7:0] e;
        if (!reqPrev && reqM) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboard unexpected req", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("scoreboard data", {24'd0, dataM}, {24'd0, e});
            end
        end
        reqPrev = reqM;
    endtask

    task automatic applyStimulus(input vec_t v);
        sel       = v.sel;
        sendValid = v.valid;
        sendData  = v.data;
        ackIn     = v.ack;
        if (v.accept) expQ.push_back(v.data);
        tick();
        scoreCheck();
    endtask

    // Global safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Basic transfer on TIMEOUT=255.
        vecs.push_back(mk("basic", 0, 1, 8'hA5, 0, 1, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 1, 0, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 1, 0));
        vecs.push_back(mk("basic", 0, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0));
        // Back-to-back with send_valid held high.
        vecs.push_back(mk("b2b", 0, 1, 8'h01, 0, 1, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 1, 0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 1, 0, 0, 1, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 1, 0, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 0, 0, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 0, 0, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 0, 0, 1, 0, 8'h01, 1, 0));
        vecs.push_back(mk("b2b", 0, 1, 8'h02, 0, 1, 0, 1, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 1, 0, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 0, 0, 1, 0, 8'h02, 1, 0));
        vecs.push_back(mk("b2b", 0, 0, 8'h00, 0, 0, 1, 0, 8'h02, 0, 0));
        // Timeout on TIMEOUT=4.
        vecs.push_back(mk("tmo", 1, 1, 8'h5A, 0, 1, 0, 1, 8'h5A, 0, 0));
        vecs.push_back(mk("tmo", 1, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 0, 0));
        vecs.push_back(mk("tmo", 1, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 0, 0));
        vecs.push_back(mk("tmo", 1, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 0, 0));
        vecs.push_back(mk("tmo", 1, 0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 1));
        vecs.push_back(mk("tmo", 1, 0, 8'h00, 0, 0, 1, 0, 8'h5A, 0, 0));
        // Late ack arriving after the abort.
        vecs.push_back(mk("late", 1, 1, 8'hC3, 0, 1, 0, 1, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 0, 1, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 0, 1, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 0, 1, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 0, 0, 8'hC3, 0, 1));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 1, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 1, 0, 1, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 1, 0, 0, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 1, 0, 0, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 1, 0, 0, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 1, 0, 0, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 0, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 1, 0, 8'hC3, 0, 0));
        vecs.push_back(mk("late", 1, 0, 8'h00, 0, 0, 1, 0, 8'hC3, 0, 0));
        // New word offered while a request is outstanding must be ignored.
        vecs.push_back(mk("ign", 0, 1, 8'hE7, 0, 1, 0, 1, 8'hE7, 0, 0));
        vecs.push_back(mk("ign", 0, 1, 8'hFF, 0, 0, 0, 1, 8'hE7, 0, 0));
        vecs.push_back(mk("ign", 0, 1, 8'hFF, 0, 0, 0, 1, 8'hE7, 0, 0));

        // Reset state.
        sel = 0; sendValid = 1'b0; sendData = 8'h00; ackIn = 1'b0; reqPrev = 1'b0;
        nRst = 1'b0;
        #2;
        checkOutput("reset in", {rdyM, reqM, doneM, terrM, dataM}, {4'b1000, 8'h00});
        tick();
        tick();
        nRst = 1'b1;
        tick();
        checkOutput("reset out", {rdyM, reqM, doneM, terrM, dataM}, {4'b1000, 8'h00});

        // Table-driven portion.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s row %0d", vecs[i].tag, i),
                        {20'd0, rdyM, reqM, doneM, terrM, dataM},
                        {20'd0, vecs[i].expReady, vecs[i].expReq, vecs[i].expDone,
                         vecs[i].expTerr, vecs[i].expData});
        end

        // Asynchronous reset mid-REQ: outputs must clear with no clock edge.
        sendValid = 1'b0;
        nRst = 1'b0;
        #2;
        checkOutput("async reset", {rdyM, reqM, doneM, terrM, dataM}, {4'b1000, 8'h00});
        reqPrev = 1'b0;
        #1;
        nRst = 1'b1;
        tick();
        checkOutput("post reset", {rdyM, reqM, doneM, terrM, dataM}, {4'b1000, 8'h00});

        // Timeout disabled: request must be held indefinitely.
        sel = 2; sendValid = 1'b1; sendData = 8'h9B;
        expQ.push_back(8'h9B);
        tick();
        scoreCheck();
        sendValid = 1'b0;
        checkOutput("dis accept", {rdyM, reqM}, 2'b01);
        for (int k = 0; k < 1000; k++) begin
            tick();
            checkOutput($sformatf("dis hold %0d", k), {reqM, terrM, doneM}, 3'b100);
        end
        ackIn = 1'b1;
        n = 0;
        while (reqM && n < 10) begin
            tick();
            n++;
        end
        checkOutput("dis req drop", {31'd0, reqM}, 32'd0);
        checkOutput("dis req drop latency", n, 3);
        ackIn = 1'b0;
        n = 0;
        while (!doneM && n < 10) begin
            tick();
            checkOutput("dis no terr", {31'd0, terrM}, 32'd0);
            n++;
        end
        checkOutput("dis done", {31'd0, doneM}, 32'd1);
        checkOutput("dis done latency", n, 3);
        checkOutput("dis ready", {31'd0, rdyM}, 32'd1);
        checkOutput("dis data", {24'd0, dataM}, {24'd0, 8'h9B});

        checkOutput("scoreboard empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
